// File: rtl/can_bit_engine.sv
// CAN bit-level front end: bus input synchroniser, quantum timing with hard
// sync and RJW-limited resync, per-bit tx/sample ticks, tx bit stuffing and
// rx destuffing with stuff-error detection.
module can_bit_engine #(
    parameter int QUANTA_PER_BIT = 100,
    parameter int SAMPLE_POINT   = 75,
    parameter int STUFF_LEN      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_raw,
    input  logic       bus_idle,
    input  logic [6:0] rjw,
    input  logic       stuff_bypass,
    input  logic       tx_data,
    output logic       tx_bit_advance,
    output logic       tx,
    output logic       rx,
    output logic       rx_data,
    output logic       rx_bit_valid,
    output logic       stuff_error
);
    localparam int CW = $clog2(QUANTA_PER_BIT);
    // Arithmetic width wide enough for counter + rjw + 1 without overflow.
    localparam int AW = ((CW > 7) ? CW : 7) + 1;
    localparam int RW = $clog2(STUFF_LEN + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(QUANTA_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_SP   = CW'(SAMPLE_POINT);
    localparam logic [AW-1:0] QPB_W    = AW'(QUANTA_PER_BIT);
    localparam logic [RW-1:0] RUN_MAX  = RW'(STUFF_LEN);
    localparam logic [RW-1:0] RUN_ONE  = RW'(1);

    logic          sync1, sync2, sync_d;
    logic          fall_edge;
    logic [CW-1:0] cnt, cnt_next;
    logic          resync_done;
    logic          hard_sync, resync;
    logic          tx_tick, sample_tick;
    logic [AW-1:0] cnt_w, rjw_w, late_j, early_rem, early_j, early_sum;
    logic [RW-1:0] tx_run, rx_run;
    logic          tx_last, rx_last;

    assign fall_edge   = sync_d & ~sync2;
    assign tx_tick     = (cnt == '0);
    assign sample_tick = (cnt == CNT_SP);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            sync1  <= rx_raw;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    // Next quantum: normal wrap, hard sync to 1, or phase correction limited by rjw.
    always_comb begin
        cnt_w     = AW'(cnt);
        rjw_w     = AW'(rjw);
        late_j    = (rjw_w < cnt_w) ? rjw_w : cnt_w;
        early_rem = QPB_W - cnt_w;
        early_j   = (rjw_w < early_rem) ? rjw_w : early_rem;
        early_sum = cnt_w + AW'(1) + early_j;
        hard_sync = fall_edge & bus_idle;
        resync    = fall_edge & ~bus_idle & ~resync_done & (cnt != '0) & (rjw != '0);
        cnt_next  = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        if (hard_sync) begin
            // The edge cycle itself stands in for the sync segment.
            cnt_next = CW'(1);
        end else if (resync) begin
            if (cnt < CNT_SP) begin
                // Late edge: hold the counter back, lengthening phase 1.
                cnt_next = CW'(cnt_w + AW'(1) - late_j);
            end else if (early_sum >= QPB_W) begin
                cnt_next = '0;
            end else begin
                // Early edge (including at the sample point): skip ahead.
                cnt_next = CW'(early_sum);
            end
        end
    end

    // Quantum counter and the once-per-bit resync guard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            resync_done <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (hard_sync || tx_tick) begin
                resync_done <= 1'b0;
            end else if (resync) begin
                resync_done <= 1'b1;
            end
        end
    end

    // Transmit path: stuff a complement bit after STUFF_LEN identical bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx             <= 1'b1;
            tx_bit_advance <= 1'b0;
            tx_run         <= '0;
            tx_last        <= 1'b1;
        end else begin
            tx_bit_advance <= 1'b0;
            if (stuff_bypass) begin
                tx_run <= '0;
            end
            if (tx_tick) begin
                if (stuff_bypass) begin
                    tx             <= tx_data;
                    tx_bit_advance <= 1'b1;
                end else if (tx_run == RUN_MAX) begin
                    tx      <= ~tx_last;
                    tx_run  <= RUN_ONE;
                    tx_last <= ~tx_last;
                end else begin
                    tx             <= tx_data;
                    tx_bit_advance <= 1'b1;
                    tx_run         <= (tx_data == tx_last) ? tx_run + RUN_ONE : RUN_ONE;
                    tx_last        <= tx_data;
                end
            end
        end
    end

    // Receive path: latch the sampled bit, drop stuff bits, flag a sixth identical bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx           <= 1'b1;
            rx_data      <= 1'b1;
            rx_bit_valid <= 1'b0;
            stuff_error  <= 1'b0;
            rx_run       <= '0;
            rx_last      <= 1'b1;
        end else begin
            rx_bit_valid <= 1'b0;
            stuff_error  <= 1'b0;
            if (stuff_bypass) begin
                rx_run <= '0;
            end
            if (sample_tick) begin
                rx <= sync2;
                if (stuff_bypass) begin
                    rx_data      <= sync2;
                    rx_bit_valid <= 1'b1;
                end else if (rx_run == RUN_MAX) begin
                    if (sync2 == rx_last) begin
                        stuff_error <= 1'b1;
                    end
                    rx_run  <= RUN_ONE;
                    rx_last <= sync2;
                end else begin
                    rx_data      <= sync2;
                    rx_bit_valid <= 1'b1;
                    rx_run       <= (sync2 == rx_last) ? rx_run + RUN_ONE : RUN_ONE;
                    rx_last      <= sync2;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_bit_engine.sv
// Directed bench for can_bit_engine: reset values, hard sync and resync
// timing, tx stuffing with loopback destuffing, rx destuffing, bypass,
// stuff error and asynchronous reset mid-bit.
module tb_can_bit_engine;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_drv;
    logic       loopback;
    logic       bus_idle;
    logic [6:0] rjw;
    logic       stuff_bypass;
    logic       tx_data;
    logic       tx_bit_advance, tx, rx, rx_data, rx_bit_valid, stuff_error;
    wire        rx_raw;

    assign rx_raw = loopback ? tx : rx_drv;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;
    int rx_q[$];
    int val_q[$];
    int adv_q[$];
    int err_q[$];

    can_bit_engine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_raw         (rx_raw),
        .bus_idle       (bus_idle),
        .rjw            (rjw),
        .stuff_bypass   (stuff_bypass),
        .tx_data        (tx_data),
        .tx_bit_advance (tx_bit_advance),
        .tx             (tx),
        .rx             (rx),
        .rx_data        (rx_data),
        .rx_bit_valid   (rx_bit_valid),
        .stuff_error    (stuff_error)
    );

    always #5 clk = ~clk;

    // Record every output pulse with the index of the clock edge that produced it.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rx_bit_valid) begin
            rx_q.push_back(int'(rx_data));
            val_q.push_back(cyc);
        end
        if (tx_bit_advance) adv_q.push_back(cyc);
        if (stuff_error) err_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_q();
        rx_q.delete();
        val_q.delete();
        adv_q.delete();
        err_q.delete();
    endtask

    function automatic int first_n(input int q[$], input int lo);
        foreach (q[i]) if (q[i] - c0 >= lo) return q[i] - c0;
        return -1;
    endfunction

    function automatic logic [31:0] pack_rx();
        logic [31:0] v = '0;
        foreach (rx_q[i]) v = {v[30:0], rx_q[i][0]};
        return v;
    endfunction

    // Falling edge with bus_idle high; returns 100 clocks after the raw edge
    // with bus edges now landing on quantum 0.
    task automatic hard_sync(input logic byp_after);
        loopback     = 1'b0;
        rx_drv       = 1'b1;
        bus_idle     = 1'b0;
        stuff_bypass = 1'b1;
        step(5);
        bus_idle = 1'b1;
        rx_drv   = 1'b0;
        c0       = cyc;
        clear_q();
        step(5);
        bus_idle = 1'b0;
        step(85);
        stuff_bypass = byp_after;
        step(10);
    endtask

    task automatic drive_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[n-1-i];
            step(100);
        end
    endtask

    task automatic resync_case(input string tag, input logic [6:0] rjw_val,
                               input int fall_n, input int exp_n);
        rjw = rjw_val;
        hard_sync(1'b1);
        rx_drv = 1'b1;
        step(fall_n - 100);
        rx_drv = 1'b0;
        step(230 - fall_n);
        chk({tag, "_first"}, first_n(adv_q, 4), 103);
        chk(tag, first_n(adv_q, 150), exp_n);
    endtask

    logic [23:0] tx_stream = 24'b100000000011111111100000;
    logic [26:0] exp_tx    = 27'b100000100001111101111000001;
    logic [26:0] exp_adv   = 27'b111111011111111101111111110;
    logic [23:0] rx_stream = 24'b100000100011111011110010;
    logic [21:0] rx_expect = 22'b1000000001111111110010;

    initial begin
        int idx;
        int nadv;
        bit got;
        rst_n        = 1'b1;
        rx_drv       = 1'b1;
        loopback     = 1'b0;
        bus_idle     = 1'b0;
        rjw          = 7'd0;
        stuff_bypass = 1'b0;
        tx_data      = 1'b1;
        #3 rst_n = 1'b0;
        #17;
        chk("rst_tx", tx, 1);
        chk("rst_rx", rx, 1);
        chk("rst_rx_data", rx_data, 1);
        chk("rst_adv", tx_bit_advance, 0);
        chk("rst_valid", rx_bit_valid, 0);
        chk("rst_err", stuff_error, 0);
        #2 rst_n = 1'b1;

        // TX stuffing, looped back into the receiver.
        loopback = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (tx_bit_advance) begin
                got = 1'b1;
                break;
            end
        end
        chk("first_advance_seen", got, 1);
        stuff_bypass = 1'b1;
        idx     = 0;
        tx_data = tx_stream[23];
        step(1);
        stuff_bypass = 1'b0;
        step(99);
        clear_q();
        nadv = 0;
        for (int k = 0; k < 27; k++) begin
            chk($sformatf("tx_bit%0d", k), tx, exp_tx[26-k]);
            chk($sformatf("tx_adv%0d", k), tx_bit_advance, exp_adv[26-k]);
            if (tx_bit_advance) begin
                nadv++;
                idx++;
                tx_data = (idx < 24) ? tx_stream[23-idx] : 1'b1;
            end
            step(100);
        end
        chk("tx_adv_count", nadv, 24);
        chk("loop_rx_count", rx_q.size(), 24);
        chk("loop_rx_bits", pack_rx(), 32'(tx_stream));
        chk("loop_rx_err", err_q.size(), 0);

        // Hard sync timing.
        rjw = 7'd0;
        hard_sync(1'b1);
        step(10);
        chk("hs_sample_valid", first_n(val_q, 4), 78);
        chk("hs_tx_tick", first_n(adv_q, 4), 103);
        chk("hs_rx", rx, 0);

        // Resync: late edge at quantum 3, early edges at 80 and at the sample point.
        resync_case("resync_rjw1", 7'd1, 103, 204);
        resync_case("resync_rjw0", 7'd0, 103, 203);
        resync_case("early_p80", 7'd10, 180, 193);
        resync_case("early_p75", 7'd10, 175, 193);

        // rjw=10 late edge, then a second edge in the same bit that must be ignored.
        rjw = 7'd10;
        hard_sync(1'b1);
        rx_drv = 1'b1;
        step(3);
        rx_drv = 1'b0;
        step(17);
        rx_drv = 1'b1;
        step(20);
        rx_drv = 1'b0;
        step(90);
        chk("resync_rjw10", first_n(adv_q, 150), 206);

        // RX destuffing.
        rjw = 7'd0;
        hard_sync(1'b0);
        clear_q();
        drive_bits(32'(rx_stream), 24);
        chk("destuff_count", rx_q.size(), 22);
        chk("destuff_bits", pack_rx(), 32'(rx_expect));
        chk("destuff_err", err_q.size(), 0);

        // Bypass: every sampled bit is delivered.
        hard_sync(1'b1);
        clear_q();
        drive_bits(32'(rx_stream), 24);
        chk("bypass_count", rx_q.size(), 24);
        chk("bypass_bits", pack_rx(), 32'(rx_stream));
        chk("bypass_err", err_q.size(), 0);

        // Stuff error on the sixth consecutive zero.
        hard_sync(1'b0);
        clear_q();
        drive_bits(32'b1000000, 7);
        chk("serr_count", err_q.size(), 1);
        chk("serr_when", first_n(err_q, 0), 778);
        chk("serr_valid_count", rx_q.size(), 6);
        chk("serr_valid_bits", pack_rx(), 32'b100000);

        // Asynchronous reset in the middle of a bit.
        step(20);
        chk("pre_reset_rx", rx, 0);
        chk("pre_reset_rx_data", rx_data, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_rx", rx, 1);
        chk("mid_rst_rx_data", rx_data, 1);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_adv", tx_bit_advance, 0);
        #10 rst_n = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
